sbox_mask_feeder: RTL and testbench

SBOX_MASK_FEEDER -- requirements
Module: sbox_mask_feeder

---
 rtl/sbox_feeder_pkg.sv | 38 +++
 rtl/xorshift32_lane.sv | 19 +
 rtl/sbox_mask_feeder.sv | 126 ++++++++++++
 tb/tb_sbox_mask_feeder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sbox_feeder_pkg.sv
// sbox_feeder_pkg: shared FSM encoding, warm-up length, PRNG helpers and randomness width functions
package sbox_feeder_pkg;

    typedef enum logic {WARM, RUN} feederState_t;

    localparam int WARM_CYCLES = 16;
    localparam logic [31:0] ZERO_SEED_SUB = 32'h9E3779B9;

    function automatic int maskWidth(int s);
        return 8 * (s - 1);
    endfunction

    function automatic int zmulWidth(int s);
        return 2 * s * (s - 1);
    endfunction

    function automatic int zinvWidth(int s);
        return s * (s - 1);
    endfunction

    function automatic int randWidth(int s);
        return maskWidth(s) + 3 * zmulWidth(s) + 3 * zinvWidth(s) + 4 * s + 3 * 2 * s;
    endfunction

    function automatic logic [31:0] xorshiftStep(logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // xorshift locks up on zero, so a zero seed is swapped for a fixed odd constant
    function automatic logic [31:0] fixSeed(logic [31:0] s);
        return (s == '0) ? ZERO_SEED_SUB : s;
    endfunction

endpackage

// File: rtl/xorshift32_lane.sv
// xorshift32_lane: one 32-bit xorshift PRNG lane, stepping every cycle, loadable with a new seed
module xorshift32_lane
    import sbox_feeder_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = 32'h0000_0001
) (
    input  logic        ClkxCI,
    input  logic        RstxRI,
    input  logic        LoadxSI,
    input  logic [31:0] SeedxDI,
    output logic [31:0] StatexDO
);

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) StatexDO <= fixSeed(RESET_SEED);
        else        StatexDO <= LoadxSI ? fixSeed(SeedxDI) : xorshiftStep(StatexDO);
    end

endmodule

// File: rtl/sbox_mask_feeder.sv
// sbox_mask_feeder: masks input bytes into shares and feeds fresh randomness to a masked AES sbox
module sbox_mask_feeder
    import sbox_feeder_pkg::*;
#(
    parameter int           SHARES  = 2,
    parameter int           LATENCY = 4,
    parameter logic [127:0] SEED    = 128'h0123456789ABCDEF_FEDCBA9876543210
) (
    input  logic                            ClkxCI,
    input  logic                            RstxRI,
    input  logic                            InValidxSI,
    output logic                            InReadyxSO,
    input  logic [7:0]                      InDataxDI,
    input  logic                            ReseedxSI,
    input  logic [127:0]                    SeedxDI,
    output logic [8*SHARES-1:0]             _XxDO,
    output logic [2*SHARES*(SHARES-1)-1:0]  _Zmul1xDO,
    output logic [2*SHARES*(SHARES-1)-1:0]  _Zmul2xDO,
    output logic [2*SHARES*(SHARES-1)-1:0]  _Zmul3xDO,
    output logic [SHARES*(SHARES-1)-1:0]    _Zinv1xDO,
    output logic [SHARES*(SHARES-1)-1:0]    _Zinv2xDO,
    output logic [SHARES*(SHARES-1)-1:0]    _Zinv3xDO,
    output logic [4*SHARES-1:0]             _Bmul1xDO,
    output logic [2*SHARES-1:0]             _Binv1xDO,
    output logic [2*SHARES-1:0]             _Binv2xDO,
    output logic [2*SHARES-1:0]             _Binv3xDO,
    output logic                            OutValidxSO
);

    localparam int MASK_W = maskWidth(SHARES);
    localparam int ZMUL_W = zmulWidth(SHARES);
    localparam int ZINV_W = zinvWidth(SHARES);
    localparam int BMUL_W = 4 * SHARES;
    localparam int BINV_W = 2 * SHARES;
    localparam int RAND_W = randWidth(SHARES);
    localparam int ZB_W   = RAND_W - MASK_W;

    // offsets of each randomness field inside the registered Z/B word
    localparam int ZI1 = 3 * ZMUL_W;
    localparam int BM1 = ZI1 + 3 * ZINV_W;
    localparam int BI1 = BM1 + BMUL_W;

    logic [127:0]         prng;
    logic                 unusedPrng;
    feederState_t         state, nextState;
    logic [3:0]           cnt, nextCnt;
    logic                 accept;
    logic [8*SHARES-1:0]  xNext;
    logic [ZB_W-1:0]      zbReg;
    logic [LATENCY:0]     vld;

    for (genvar k = 0; k < 4; k++) begin : gLane
        xorshift32_lane #(
            .RESET_SEED(SEED[32*k +: 32])
        ) uLane (
            .ClkxCI  (ClkxCI),
            .RstxRI  (RstxRI),
            .LoadxSI (ReseedxSI),
            .SeedxDI (SeedxDI[32*k +: 32]),
            .StatexDO(prng[32*k +: 32])
        );
    end

    assign unusedPrng = ^prng[127:RAND_W];

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            state <= WARM;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    always_comb begin
        nextState  = state;
        nextCnt    = cnt;
        InReadyxSO = (state == RUN) && !ReseedxSI;
        if (ReseedxSI) begin
            nextState = WARM;
            nextCnt   = '0;
        end else if (state == WARM) begin
            nextCnt   = cnt + 4'd1;
            nextState = (cnt == 4'(WARM_CYCLES - 1)) ? RUN : WARM;
        end
    end

    assign accept = InValidxSI && InReadyxSO;

    // share 0 carries the data under every mask; shares 1.. are the masks themselves
    always_comb begin
        xNext      = '0;
        xNext[7:0] = InDataxDI;
        for (int i = 1; i < SHARES; i++) begin
            xNext[7:0]   = xNext[7:0] ^ prng[8*(i-1) +: 8];
            xNext[8*i +: 8] = prng[8*(i-1) +: 8];
        end
    end

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            _XxDO       <= '0;
            zbReg       <= '0;
            vld         <= '0;
            OutValidxSO <= 1'b0;
        end else begin
            zbReg       <= prng[RAND_W-1:MASK_W];
            vld         <= {vld[LATENCY-1:0], accept};
            OutValidxSO <= vld[LATENCY];
            if (accept) _XxDO <= xNext;
        end
    end

    assign _Zmul1xDO = zbReg[0 +: ZMUL_W];
    assign _Zmul2xDO = zbReg[ZMUL_W +: ZMUL_W];
    assign _Zmul3xDO = zbReg[2*ZMUL_W +: ZMUL_W];
    assign _Zinv1xDO = zbReg[ZI1 +: ZINV_W];
    assign _Zinv2xDO = zbReg[ZI1 + ZINV_W +: ZINV_W];
    assign _Zinv3xDO = zbReg[ZI1 + 2*ZINV_W +: ZINV_W];
    assign _Bmul1xDO = zbReg[BM1 +: BMUL_W];
    assign _Binv1xDO = zbReg[BI1 +: BINV_W];
    assign _Binv2xDO = zbReg[BI1 + BINV_W +: BINV_W];
    assign _Binv3xDO = zbReg[BI1 + 2*BINV_W +: BINV_W];

endmodule

// File: tb/tb_sbox_mask_feeder.sv
// tb_sbox_mask_feeder: drives SHARES=2 and SHARES=3 feeders in lockstep against a behavioural model
module tb_sbox_mask_feeder;

    localparam logic [127:0] SEED = 128'h0123456789ABCDEF_FEDCBA9876543210;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inValid = 1'b0;
    logic [7:0] inData = '0;
    logic reseed = 1'b0;
    logic [127:0] seedIn = '0;

    logic ready2, ready3, outValid2, outValid3;
    logic [15:0] x2;
    logic [23:0] x3;
    logic [3:0]  zm1_2, zm2_2, zm3_2;
    logic [1:0]  zi1_2, zi2_2, zi3_2;
    logic [7:0]  bm1_2;
    logic [3:0]  bi1_2, bi2_2, bi3_2;
    logic [11:0] zm1_3, zm2_3, zm3_3;
    logic [5:0]  zi1_3, zi2_3, zi3_3;
    logic [11:0] bm1_3;
    logic [5:0]  bi1_3, bi2_3, bi3_3;
    logic [37:0] zb2;
    logic [83:0] zb3;

    assign zb2 = {bi3_2, bi2_2, bi1_2, bm1_2, zi3_2, zi2_2, zi1_2, zm3_2, zm2_2, zm1_2};
    assign zb3 = {bi3_3, bi2_3, bi1_3, bm1_3, zi3_3, zi2_3, zi1_3, zm3_3, zm2_3, zm1_3};

    always #5 clk = ~clk;

    sbox_mask_feeder #(.SHARES(2), .LATENCY(4), .SEED(SEED)) dut2 (
        .ClkxCI(clk), .RstxRI(rst), .InValidxSI(inValid), .InReadyxSO(ready2), .InDataxDI(inData),
        .ReseedxSI(reseed), .SeedxDI(seedIn), ._XxDO(x2),
        ._Zmul1xDO(zm1_2), ._Zmul2xDO(zm2_2), ._Zmul3xDO(zm3_2),
        ._Zinv1xDO(zi1_2), ._Zinv2xDO(zi2_2), ._Zinv3xDO(zi3_2),
        ._Bmul1xDO(bm1_2), ._Binv1xDO(bi1_2), ._Binv2xDO(bi2_2), ._Binv3xDO(bi3_2),
        .OutValidxSO(outValid2)
    );

    sbox_mask_feeder #(.SHARES(3), .LATENCY(4), .SEED(SEED)) dut3 (
        .ClkxCI(clk), .RstxRI(rst), .InValidxSI(inValid), .InReadyxSO(ready3), .InDataxDI(inData),
        .ReseedxSI(reseed), .SeedxDI(seedIn), ._XxDO(x3),
        ._Zmul1xDO(zm1_3), ._Zmul2xDO(zm2_3), ._Zmul3xDO(zm3_3),
        ._Zinv1xDO(zi1_3), ._Zinv2xDO(zi2_3), ._Zinv3xDO(zi3_3),
        ._Bmul1xDO(bm1_3), ._Binv1xDO(bi1_3), ._Binv2xDO(bi2_3), ._Binv3xDO(bi3_3),
        .OutValidxSO(outValid3)
    );

    int total = 0;
    int fails = 0;
    int cyc = 0;
    int warm = 0;
    int pulses = 0;
    bit lastAcc = 0;
    bit hist[4096];
    logic [31:0] m[4];
    logic [15:0] expX2 = '0;
    logic [23:0] expX3 = '0;
    logic [37:0] expZb2 = '0;
    logic [83:0] expZb3 = '0;
    logic [37:0] rec[20];

    function automatic logic [31:0] xs(logic [31:0] x);
        x ^= x << 13;
        x ^= x >> 17;
        x ^= x << 5;
        return x;
    endfunction

    function automatic logic [31:0] fix(logic [31:0] s);
        return (s == 32'd0) ? 32'h9E3779B9 : s;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock: model predicts from spec rules, then both DUTs are compared
    task automatic tick();
        bit rdy, acc;
        logic [127:0] pre;
        #1;
        rdy = !rst && warm >= 16 && !reseed;
        chk("ready2", ready2, rdy);
        chk("ready3", ready3, rdy);
        acc = inValid && rdy;
        pre = {m[3], m[2], m[1], m[0]};
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int k = 0; k < 4; k++) m[k] = fix(SEED[32*k +: 32]);
            warm = 0;
            expX2 = '0;
            expX3 = '0;
            expZb2 = '0;
            expZb3 = '0;
            foreach (hist[i]) hist[i] = 0;
        end else begin
            expZb2 = pre[45:8];
            expZb3 = pre[99:16];
            if (acc) begin
                expX2 = {pre[7:0], inData ^ pre[7:0]};
                expX3 = {pre[15:8], pre[7:0], inData ^ pre[7:0] ^ pre[15:8]};
                hist[cyc] = 1;
            end
            for (int k = 0; k < 4; k++) m[k] = reseed ? fix(seedIn[32*k +: 32]) : xs(m[k]);
            warm = reseed ? 0 : (warm < 16 ? warm + 1 : 16);
        end
        lastAcc = acc;
        #1;
        chk("x2", x2, expX2);
        chk("x3", x3, expX3);
        chk("zb2", zb2, expZb2);
        chk("zb3", zb3, expZb3);
        chk("outValid2", outValid2, (cyc >= 5) ? hist[cyc-5] : 1'b0);
        chk("outValid3", outValid3, (cyc >= 5) ? hist[cyc-5] : 1'b0);
        if (outValid2) pulses++;
    endtask

    task automatic doReset();
        #1;
        rst = 1'b1;
        #1;
        chk("rstOutValid", {outValid3, outValid2}, 2'b00);
        chk("rstX", {x3, x2}, '0);
        chk("rstZb", {zb3, zb2}, '0);
        chk("rstReady", {ready3, ready2}, 2'b00);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int b, n, firstAt;
        tick();
        tick();
        rst = 1'b0;
        // back-to-back byte stream 0x00..0xFF straight out of reset
        inValid = 1'b1;
        b = 0;
        n = 0;
        firstAt = 0;
        inData = 8'h00;
        while (b < 256 && n < 2000) begin
            tick();
            n++;
            if (lastAcc) begin
                if (b == 0) firstAt = n;
                b++;
                inData = 8'(b);
            end
        end
        chk("firstAccept", firstAt, 17);
        chk("bytesAccepted", b, 256);
        inValid = 1'b0;
        repeat (7) tick();
        chk("pulseCount", pulses, 256);
        // determinism: same SEED reproduces the same Z/B stream
        doReset();
        for (int i = 0; i < 20; i++) begin
            tick();
            rec[i] = zb2;
        end
        doReset();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("rerunZb", zb2, rec[i]);
        end
        // reseed with zero seed in the middle of a stream
        inValid = 1'b1;
        inData = 8'hA5;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            inData = inData + 8'd1;
        end
        reseed = 1'b1;
        seedIn = '0;
        tick();
        chk("reseedDrop", lastAcc, 1'b0);
        reseed = 1'b0;
        n = 0;
        lastAcc = 0;
        while (!lastAcc && n < 40) begin
            tick();
            n++;
            if (n == 2) chk("zeroSeedNonzero", zb2 != '0, 1'b1);
        end
        chk("reseedWarm", n, 17);
        // reset while three bytes are in flight
        repeat (3) begin
            tick();
            inData = inData ^ 8'h3C;
        end
        doReset();
        inValid = 1'b0;
        repeat (8) tick();
        // random traffic with occasional reseeds, some lanes zero
        for (int i = 0; i < 400; i++) begin
            inValid = ($urandom % 4) != 0;
            inData = 8'($urandom);
            reseed = ($urandom % 50) == 0;
            for (int k = 0; k < 4; k++) seedIn[32*k +: 32] = ($urandom % 2) ? $urandom : 32'd0;
            tick();
        end
        reseed = 1'b0;
        inValid = 1'b0;
        repeat (6) tick();
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
